booth_mul_seq: RTL

- Multi-cycle signed 32x32 -> 64-bit multiplier for the MUL instruction.
- Sits between the register-file operand buses and the HI/LO (ZHigh/ZLow) result registers.
- Radix-2 Booth, one iteration per clock; each iteration adds or subtracts the multiplicand into a 33-bit accumulator through an add/subtract path (carry-in = 1 for subtract).
- Exposes a start/busy/done handshake so the control unit can stall until the product is ready.

---
 rtl/booth_mul_seq.sv | 124 ++++++++++++
 1 files changed

// File: rtl/booth_mul_seq.sv
`default_nettype none
// ============================================================================
// booth_mul_seq : sequential radix-2 Booth signed multiplier, 1 bit per clock
// Revision 1.0
// ============================================================================
module booth_mul_seq #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             start,
   input  logic [WIDTH-1:0] multiplicand,
   input  logic [WIDTH-1:0] multiplier,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] product_hi,
   output logic [WIDTH-1:0] product_lo
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH:0]   m_q,     m_d;
   logic [WIDTH:0]   acc_q,   acc_d;
   logic [WIDTH-1:0] qr_q,    qr_d;
   logic             qm1_q,   qm1_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;
   logic [WIDTH-1:0] hi_q,    hi_d;
   logic [WIDTH-1:0] lo_q,    lo_d;

   logic             booth_add;
   logic             booth_sub;
   logic [WIDTH:0]   addend;
   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   acc_sel;
   logic [WIDTH:0]   acc_sh;
   logic [WIDTH-1:0] qr_sh;
   logic             last_iter;

   // Subtract is add of the inverted multiplicand with carry-in of one.
   assign booth_add = ({qr_q[0], qm1_q} == 2'b01);
   assign booth_sub = ({qr_q[0], qm1_q} == 2'b10);
   assign addend    = booth_sub ? ~m_q : m_q;
   assign sum       = acc_q + addend + {{WIDTH{1'b0}}, booth_sub};
   assign acc_sel   = (booth_add || booth_sub) ? sum : acc_q;
   assign acc_sh    = {acc_sel[WIDTH], acc_sel[WIDTH:1]};
   assign qr_sh     = {acc_sel[0], qr_q[WIDTH-1:1]};
   assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

   always_ff @(posedge clk) begin
      if (clr) begin
         state_q <= S_IDLE;
         m_q     <= '0;
         acc_q   <= '0;
         qr_q    <= '0;
         qm1_q   <= 1'b0;
         cnt_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         m_q     <= m_d;
         acc_q   <= acc_d;
         qr_q    <= qr_d;
         qm1_q   <= qm1_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   always_comb begin
      state_d = state_q;
      m_d     = m_q;
      acc_d   = acc_q;
      qr_d    = qr_q;
      qm1_d   = qm1_q;
      cnt_d   = cnt_q;
      hi_d    = hi_q;
      lo_d    = lo_q;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d = S_RUN;
               m_d     = {multiplicand[WIDTH-1], multiplicand};
               acc_d   = '0;
               qr_d    = multiplier;
               qm1_d   = 1'b0;
               cnt_d   = '0;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_RUN: begin
            acc_d = acc_sh;
            qr_d  = qr_sh;
            qm1_d = qr_q[0];
            cnt_d = cnt_q + CNT_W'(1);
            if (last_iter) begin
               // The 65-bit {acc, Q} holds the product; bit 64 is a pure sign copy.
               hi_d    = acc_sh[WIDTH-1:0];
               lo_d    = qr_sh;
               state_d = S_DONE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign busy       = (state_q == S_RUN);
   assign done       = (state_q == S_DONE);
   assign product_hi = hi_q;
   assign product_lo = lo_q;

endmodule
`default_nettype wire
